bcd_convert_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Replaces the fixed 32-bit / 8-digit combinational conversion in the temperature display path.
- Decouples the arithmetic from the display timing with valid/ready handshakes on both sides.
- Sits between the temperature scaling logic and the seven-segment display driver; adds overflow detection and optional leading-zero blanking.

---
 rtl/bcd_convert_seq.sv | 134 +++++++++++++
 tb/tb_bcd_convert_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock) with valid/ready on both sides.
// Optional leading-zero blanking output digit_en is compiled in with `define BCD_BLANK_EN.
module bcd_convert_seq #(
  parameter int BIN_WIDTH  = 32,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_WIDTH-1:0]    bin_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_DIGITS*4-1:0] bcd_out,
  output logic                    overflow
`ifdef BCD_BLANK_EN
  ,
  output logic [NUM_DIGITS-1:0]   digit_en
`endif
);

  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  // Wide enough accumulators can never carry out of the top digit.
  localparam bit OVF_POSSIBLE = (BCD_W < BIN_WIDTH + (BIN_WIDTH + 2) / 3);

  // Handshake: a transfer happens on a rising clk edge where valid && ready;
  // valid, data and overflow stay stable until that edge.
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e                state_q;
  logic [BIN_WIDTH-1:0]  bin_sr_q;
  logic [BCD_W-1:0]      bcd_acc_q;
  logic                  ovf_acc_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [BCD_W-1:0]      bcd_out_q;
  logic                  overflow_q;

  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W-1:0]      bcd_shift_d;
  logic [BIN_WIDTH-1:0]  bin_shift_d;
  logic                  ovf_d;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_acc_q[i*4 +: 4] > 4'd4) bcd_adj[i*4 +: 4] = bcd_acc_q[i*4 +: 4] + 4'd3;
      else                            bcd_adj[i*4 +: 4] = bcd_acc_q[i*4 +: 4];
    end
    {bcd_shift_d, bin_shift_d} = {bcd_adj[BCD_W-2:0], bin_sr_q, 1'b0};
    ovf_d = OVF_POSSIBLE ? (ovf_acc_q | bcd_adj[BCD_W-1]) : 1'b0;
  end

`ifdef BCD_BLANK_EN
  logic [NUM_DIGITS-1:0] digit_en_q;
  logic [NUM_DIGITS-1:0] en_d;
  logic                  seen;

  // A digit is shown when it or any more significant digit is non-zero.
  always_comb begin
    en_d = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (|bcd_shift_d[i*4 +: 4]);
      en_d[i] = seen | ovf_d | (i == 0);
    end
  end

  assign digit_en = digit_en_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_sr_q    <= '0;
      bcd_acc_q   <= '0;
      ovf_acc_q   <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bcd_out_q   <= '0;
      overflow_q  <= 1'b0;
`ifdef BCD_BLANK_EN
      digit_en_q  <= '1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            bin_sr_q   <= bin_in;
            bcd_acc_q  <= '0;
            ovf_acc_q  <= 1'b0;
            cnt_q      <= CNT_W'(BIN_WIDTH);
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr_q  <= bin_shift_d;
          bcd_acc_q <= bcd_shift_d;
          ovf_acc_q <= ovf_d;
          cnt_q     <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            bcd_out_q   <= bcd_shift_d;
            overflow_q  <= ovf_d;
`ifdef BCD_BLANK_EN
            digit_en_q  <= en_d;
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed bench for bcd_convert_seq: default 32b/8-digit unit plus 32/10, 8/3 and 8/2 variants.
module tb_bcd_convert_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Unit a: BIN_WIDTH=32, NUM_DIGITS=8
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, overflow_a;
  logic [31:0] bin_in_a, bcd_out_a;
  // Unit b: BIN_WIDTH=32, NUM_DIGITS=10
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, overflow_b;
  logic [31:0] bin_in_b;
  logic [39:0] bcd_out_b;
  // Unit c: BIN_WIDTH=8, NUM_DIGITS=3
  logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, overflow_c;
  logic [7:0]  bin_in_c;
  logic [11:0] bcd_out_c;
  // Unit d: BIN_WIDTH=8, NUM_DIGITS=2
  logic        in_valid_d, in_ready_d, out_valid_d, out_ready_d, overflow_d;
  logic [7:0]  bin_in_d;
  logic [7:0]  bcd_out_d;
`ifdef BCD_BLANK_EN
  logic [7:0]  digit_en_a;
  logic [9:0]  digit_en_b;
  logic [2:0]  digit_en_c;
  logic [1:0]  digit_en_d;
`endif

  bcd_convert_seq #(.BIN_WIDTH(32), .NUM_DIGITS(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .bin_in(bin_in_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .bcd_out(bcd_out_a), .overflow(overflow_a)
`ifdef BCD_BLANK_EN
    , .digit_en(digit_en_a)
`endif
  );
  bcd_convert_seq #(.BIN_WIDTH(32), .NUM_DIGITS(10)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .bin_in(bin_in_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .bcd_out(bcd_out_b), .overflow(overflow_b)
`ifdef BCD_BLANK_EN
    , .digit_en(digit_en_b)
`endif
  );
  bcd_convert_seq #(.BIN_WIDTH(8), .NUM_DIGITS(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .bin_in(bin_in_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .bcd_out(bcd_out_c), .overflow(overflow_c)
`ifdef BCD_BLANK_EN
    , .digit_en(digit_en_c)
`endif
  );
  bcd_convert_seq #(.BIN_WIDTH(8), .NUM_DIGITS(2)) u_d (
    .clk(clk), .rst(rst), .in_valid(in_valid_d), .in_ready(in_ready_d), .bin_in(bin_in_d),
    .out_valid(out_valid_d), .out_ready(out_ready_d), .bcd_out(bcd_out_d), .overflow(overflow_d)
`ifdef BCD_BLANK_EN
    , .digit_en(digit_en_d)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic aux_valid(input int which);
    case (which)
      1:       return out_valid_b;
      2:       return out_valid_c;
      default: return out_valid_d;
    endcase
  endfunction

  function automatic logic [39:0] aux_bcd(input int which);
    case (which)
      1:       return bcd_out_b;
      2:       return 40'(bcd_out_c);
      default: return 40'(bcd_out_d);
    endcase
  endfunction

  function automatic logic aux_ovf(input int which);
    case (which)
      1:       return overflow_b;
      2:       return overflow_c;
      default: return overflow_d;
    endcase
  endfunction

`ifdef BCD_BLANK_EN
  function automatic logic [9:0] aux_en(input int which);
    case (which)
      1:       return digit_en_b;
      2:       return 10'(digit_en_c);
      default: return 10'(digit_en_d);
    endcase
  endfunction
`endif

  // One conversion on unit a; stall=1 holds out_ready low for 20 cycles after out_valid.
  task automatic run_a(input logic [31:0] v, input logic [31:0] exp_bcd, input logic exp_ovf,
                       input logic [7:0] exp_en, input bit stall);
    int n;
    logic [31:0] exp;
    logic [31:0] snap;
    bit stable;
    exp_q.push_back(exp_bcd);
    @(negedge clk);
    check("a_in_ready_idle", 64'(in_ready_a), 64'd1);
    in_valid_a  = 1'b1;
    bin_in_a    = v;
    out_ready_a = !stall;
    @(negedge clk);
    in_valid_a = 1'b0;
    bin_in_a   = $urandom;
    check("a_in_ready_busy", 64'(in_ready_a), 64'd0);
    n = 0;
    while (!out_valid_a && n < 100) begin
      in_valid_a = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    in_valid_a = 1'b0;
    check("a_latency", 64'(n), 64'd32);
    exp = exp_q.pop_front();
    check("a_bcd", 64'(bcd_out_a), 64'(exp));
    check("a_ovf", 64'(overflow_a), 64'(exp_ovf));
`ifdef BCD_BLANK_EN
    check("a_digit_en", 64'(digit_en_a), 64'(exp_en));
`else
    if (exp_en == 8'h00) $display("note: zero enable vector given for 0x%0h", v);
`endif
    if (stall) begin
      snap   = bcd_out_a;
      stable = 1'b1;
      repeat (20) begin
        in_valid_a = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (!out_valid_a || bcd_out_a !== snap || overflow_a !== exp_ovf || in_ready_a) stable = 1'b0;
      end
      in_valid_a = 1'b0;
      check("a_stall_hold", 64'(stable), 64'd1);
      out_ready_a = 1'b1;
    end
    @(negedge clk);
    check("a_valid_cleared", 64'(out_valid_a), 64'd0);
    check("a_in_ready_back", 64'(in_ready_a), 64'd1);
    check("a_bcd_kept", 64'(bcd_out_a), 64'(exp));
  endtask

  task automatic run_aux(input int which, input logic [31:0] v, input logic [39:0] exp_bcd,
                         input logic exp_ovf, input logic [9:0] exp_en, input int lat);
    int n;
    @(negedge clk);
    case (which)
      1:       begin in_valid_b = 1'b1; bin_in_b = v;      end
      2:       begin in_valid_c = 1'b1; bin_in_c = v[7:0]; end
      default: begin in_valid_d = 1'b1; bin_in_d = v[7:0]; end
    endcase
    @(negedge clk);
    in_valid_b = 1'b0;
    in_valid_c = 1'b0;
    in_valid_d = 1'b0;
    n = 0;
    while (!aux_valid(which) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d_latency", which), 64'(n), 64'(lat));
    check($sformatf("u%0d_bcd_%0d", which, v), 64'(aux_bcd(which)), 64'(exp_bcd));
    check($sformatf("u%0d_ovf_%0d", which, v), 64'(aux_ovf(which)), 64'(exp_ovf));
`ifdef BCD_BLANK_EN
    check($sformatf("u%0d_en_%0d", which, v), 64'(aux_en(which)), 64'(exp_en));
`else
    if (exp_en == 10'h000) $display("note: zero enable vector given for %0d", v);
`endif
    @(negedge clk);
  endtask

  initial begin
    bit seen_valid;
    rst = 1'b1;
    in_valid_a = 1'b0; bin_in_a = '0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; bin_in_b = '0; out_ready_b = 1'b1;
    in_valid_c = 1'b0; bin_in_c = '0; out_ready_c = 1'b1;
    in_valid_d = 1'b0; bin_in_d = '0; out_ready_d = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready_a), 64'd1);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_bcd", 64'(bcd_out_a), 64'd0);
    check("rst_ovf", 64'(overflow_a), 64'd0);
`ifdef BCD_BLANK_EN
    check("rst_digit_en", 64'(digit_en_a), 64'hFF);
`endif
    rst = 1'b0;

    run_a(32'd0,         32'h00000000, 1'b0, 8'h01, 1'b0);
    run_a(32'd12345678,  32'h12345678, 1'b0, 8'hFF, 1'b0);
    run_a(32'd99999999,  32'h99999999, 1'b0, 8'hFF, 1'b0);
    run_a(32'd100000000, 32'h00000000, 1'b1, 8'hFF, 1'b0);
    run_a(32'd87654321,  32'h87654321, 1'b0, 8'hFF, 1'b1);

    // Abort a conversion with reset ten cycles in.
    @(negedge clk);
    in_valid_a = 1'b1;
    bin_in_a   = 32'd12345;
    @(negedge clk);
    in_valid_a = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid_a), 64'd0);
    check("abort_bcd", 64'(bcd_out_a), 64'd0);
    check("abort_ovf", 64'(overflow_a), 64'd0);
    check("abort_in_ready", 64'(in_ready_a), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_a) seen_valid = 1'b1;
    end
    check("abort_no_valid", 64'(seen_valid), 64'd0);

    run_a(32'd42,  32'h00000042, 1'b0, 8'h03, 1'b0);
    run_a(32'd305, 32'h00000305, 1'b0, 8'h07, 1'b0);

    run_aux(1, 32'hFFFFFFFF,  40'h4294967295, 1'b0, 10'h3FF, 32);
    run_aux(1, 32'd100000000, 40'h0100000000, 1'b0, 10'h1FF, 32);
    run_aux(2, 32'd255, 40'h255, 1'b0, 10'h7, 8);
    run_aux(2, 32'd7,   40'h007, 1'b0, 10'h1, 8);
    run_aux(2, 32'd0,   40'h000, 1'b0, 10'h1, 8);
    run_aux(3, 32'd99,  40'h99,  1'b0, 10'h3, 8);
    run_aux(3, 32'd100, 40'h00,  1'b1, 10'h3, 8);
    run_aux(3, 32'd255, 40'h55,  1'b1, 10'h3, 8);
    run_aux(3, 32'd9,   40'h09,  1'b0, 10'h1, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
